fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//   Instruction-fetch stage for the RV32I core. Owns the PC register, issues one word fetch at a time
//   to instruction memory and hands the fetched instruction to decode through a valid/ready buffer.
//   Consumes the execute-stage branch decision (branched, branch_target) to redirect the PC and flush
//   younger in-flight fetches. Sits directly downstream of the branch-condition evaluator.
// PARAMETERS
//   RESET_PC   32'h0000_0000   PC value loaded on reset; must be word aligned
// PORTS
//   clk            in   1    core clock; all state updates on rising edge
//   rst_n          in   1    asynchronous, active-low reset
//   branched       in   1    execute stage: take redirect this cycle (taken branch or JMP)
//   branch_target  in   32   redirect PC, valid when branched=1
//   imem_req       out  1    fetch request to instruction memory
//   imem_addr      out  32   fetch address, equals the PC register
//   imem_gnt       in   1    memory accepted request this cycle
//   imem_rvalid    in   1    read data valid, exactly one per accepted request, >=1 cycle after gnt
//   imem_rdata     in   32   instruction word
//   if_valid       out  1    instruction buffer holds a valid instruction
//   if_pc          out  32   PC of buffered instruction
//   if_instr       out  32   buffered instruction
//   if_ready       in   1    decode accepts the buffer this cycle (transfer = if_valid & if_ready)
//   fetch_misalign out  1    only when FETCH_ALIGN_CHECK_EN is defined; see CONFIGURATION
// BEHAVIOUR
//   Reset (async, rst_n=0): pc=RESET_PC, state=S_REQ, kill=0, if_valid=0, if_pc=0, if_instr=0,
//     fetch_misalign=0. imem_req is 0 while rst_n=0. First request is issued in the first cycle after
//     reset is released. Reset mid-transaction abandons any outstanding request; a late imem_rvalid
//     after reset is ignored only if it arrives while state=S_REQ.
//   States:
//     S_REQ : imem_req=1, imem_addr=pc. On imem_gnt: go to S_WAIT.
//     S_WAIT: imem_req=0. On imem_rvalid and kill=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1,
//             pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0), go to S_HOLD. On imem_rvalid and kill=1:
//             drop data, kill<=0, go to S_REQ.
//     S_HOLD: if_valid=1. On if_valid&if_ready: if_valid<=0, go to S_REQ; the next request is issued
//             the following cycle. Fetch latency: req-to-if_valid = gnt cycle + rvalid cycle + 1 edge.
//   Redirect (branched=1) has priority over every other event in the same cycle:
//     pc<=branch_target; if_valid<=0, and the held instruction is discarded even if if_ready=1.
//     S_REQ, no gnt        -> stay in S_REQ; imem_addr shows the new pc next cycle.
//     S_REQ with gnt       -> S_WAIT, kill<=1 (stale request in flight).
//     S_WAIT, no rvalid    -> stay in S_WAIT, kill<=1.
//     S_WAIT with rvalid   -> response dropped, kill<=0, go to S_REQ.
//     S_HOLD               -> S_REQ.
//   Only one request is outstanding at any time; imem_gnt outside S_REQ is ignored.
//   if_pc/if_instr are stable while if_valid=1 and no transfer or redirect occurs.
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined: port fetch_misalign exists. A redirect with branch_target[1:0]!=0
//     loads pc as usual, kills any in-flight request as above, then enters S_FAULT: imem_req=0,
//     if_valid=0, fetch_misalign=1 (held). The unit leaves S_FAULT only on a redirect to an aligned
//     target: fetch_misalign<=0, go to S_REQ. A misaligned redirect in S_WAIT waits for the killed
//     rvalid and then enters S_FAULT.
//   Not defined: no fetch_misalign port. pc<={branch_target[31:2],2'b00} on every redirect.
// TESTING
//   1 Reset release, gnt at once, rvalid 1 cycle later, if_ready=1 -> fetches 0x0,0x4,0x8 in order;
//     if_pc matches each, and if_instr equals the memory word.
//   2 if_ready=0 for 5 cycles with if_valid=1 -> if_pc/if_instr held, imem_req=0, pc=if_pc+4.
//   3 branched=1, target=0x100, in S_WAIT 2 cycles before rvalid -> that rvalid is dropped, next
//     request addr=0x100, and the first if_pc=0x100.
//   4 branched=1 and imem_rvalid in the same cycle -> no if_valid; next imem_addr=target.
//   5 branched=1 in S_HOLD with if_ready=1 -> no transfer counted, if_valid=0 next cycle;
//     pc=0xFFFF_FFFC fetch -> next pc=0x0.
//   6 FETCH_ALIGN_CHECK_EN: target=0x102 -> fetch_misalign=1 and no imem_req; then target=0x200 ->
//     fetch_misalign=0 and req addr=0x200. Without the macro: target=0x102 -> req addr=0x100.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and
// buffers the returned instruction for decode behind a valid/ready handshake.
// Branch redirects from execute replace the PC and kill any in-flight fetch.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds fetch_misalign and a fault
// state entered on redirects to non-word-aligned targets.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branched,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  typedef enum logic [1:0] {StReq, StWait, StHold, StFault} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  // Misaligned redirect seen while a killed response is still outstanding.
  logic        pend_q, pend_d;
  logic        valid_q, valid_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] instr_q, instr_d;

  logic [31:0] redir_pc;
  logic        tgt_bad;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_pc = branch_target;
  assign tgt_bad  = |branch_target[1:0];
`else
  assign redir_pc = branch_target & ~32'h3;
  assign tgt_bad  = 1'b0;
`endif

  // Next-state: redirect takes priority over every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    case (state_q)
      StReq: begin
        if (branched) begin
          pc_d = redir_pc;
          if (imem_gnt) begin
            state_d = StWait;
            kill_d  = 1'b1;
            pend_d  = tgt_bad;
          end else if (tgt_bad) begin
            state_d = StFault;
          end
        end else if (imem_gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (branched) begin
            pc_d    = redir_pc;
            kill_d  = 1'b0;
            pend_d  = 1'b0;
            state_d = tgt_bad ? StFault : StReq;
          end else if (kill_q) begin
            kill_d  = 1'b0;
            pend_d  = 1'b0;
            state_d = pend_q ? StFault : StReq;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = StHold;
          end
        end else if (branched) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
          pend_d = tgt_bad;
        end
      end
      StHold: begin
        if (branched) begin
          pc_d    = redir_pc;
          valid_d = 1'b0;
          state_d = tgt_bad ? StFault : StReq;
        end else if (if_ready) begin
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      StFault: begin
        if (branched) begin
          pc_d = redir_pc;
          if (!tgt_bad) state_d = StReq;
        end
      end
      default: state_d = StReq;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReq;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      ipc_q   <= 32'h0;
      instr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
    end
  end

  // Outputs decode from state only; request is suppressed while in reset.
  always_comb begin
    imem_req  = rst_n & (state_q == StReq);
    imem_addr = pc_q;
    if_valid  = valid_q;
    if_pc     = ipc_q;
    if_instr  = instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fetch_misalign = (state_q == StFault);
`endif
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a per-cycle vector table plus hand-written
// sequences for alignment fault and reset-during-fetch cases.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branched;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int nchecks = 0;
  int nerrs   = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .branched      (branched),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .if_ready      (if_ready)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  typedef struct {
    logic        br;
    logic [31:0] tgt;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  // Memory contents model: each word derived from its address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(input logic br, input logic [31:0] tgt, input logic gnt,
                              input logic rv, input logic [31:0] rd, input logic rdy,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pc);
    vec_t v;
    v.br = br; v.tgt = tgt; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic [31:0] tgt, input logic gnt,
                       input logic rv, input logic [31:0] rd, input logic rdy);
    branched = br; branch_target = tgt; imem_gnt = gnt;
    imem_rvalid = rv; imem_rdata = rd; if_ready = rdy;
    @(negedge clk);
    branched = 1'b0; branch_target = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr,
                         input logic valid);
    chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, req});
    chk({tag, ".addr"}, imem_addr, addr);
    chk({tag, ".valid"}, {31'h0, if_valid}, {31'h0, valid});
  endtask

  initial begin
    rst_n = 1'b0;
    branched = 1'b0; branch_target = 32'h0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; if_ready = 1'b0;

    //              br tgt           gnt rv rdata                  rdy  req addr          v  pc
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'h0),            0,  0, 32'h0,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 1,  0, 32'h4,         1, 32'h0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'h4,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'h4),            0,  0, 32'h4,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 1,  0, 32'h8,         1, 32'h4));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'h8,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'h8),            0,  0, 32'h8,         0, 32'h0));
    // decode stalls for five cycles
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 32'h0,      0, 0, 32'h0,                 0,  0, 32'hC,         1, 32'h8));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 1,  0, 32'hC,         1, 32'h8));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 0,  1, 32'hC,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'hC,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  0, 32'hC,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'hC),            0,  0, 32'hC,         0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 1,  0, 32'h10,        1, 32'hC));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'h10,        0, 32'h0));
    // redirect while waiting; stale response two cycles later is dropped
    vecs.push_back(mk(1, 32'h100,      0, 0, 32'h0,                 0,  0, 32'h10,        0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 0,  0, 32'h100,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'h10),           0,  0, 32'h100,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'h100,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'h100),          0,  0, 32'h100,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 1,  0, 32'h104,       1, 32'h100));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'h104,       0, 32'h0));
    // redirect coincident with rvalid
    vecs.push_back(mk(1, 32'h200,      0, 1, mem(32'h104),          0,  0, 32'h104,       0, 32'h0));
    // redirect coincident with gnt
    vecs.push_back(mk(1, 32'h300,      1, 0, 32'h0,                 0,  1, 32'h200,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, 32'hDEAD_0000,         0,  0, 32'h300,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'h300,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'h300),          0,  0, 32'h300,       0, 32'h0));
    // redirect in hold with if_ready=1 discards the instruction
    vecs.push_back(mk(1, 32'h400,      0, 0, 32'h0,                 1,  0, 32'h304,       1, 32'h300));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 32'h0,                0,  1, 32'h400,       0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,                 0,  1, 32'hFFFF_FFFC, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 1, mem(32'hFFFF_FFFC),    0,  0, 32'hFFFF_FFFC, 0, 32'h0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 1,  0, 32'h0,         1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,                 0,  1, 32'h0,         0, 32'h0));

    // Reset state
    repeat (2) @(negedge clk);
    chk_bus("reset", 1'b0, 32'h0, 1'b0);
    chk("reset.if_pc", if_pc, 32'h0);
    chk("reset.if_instr", if_instr, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("reset.misalign", {31'h0, fetch_misalign}, 32'h0);
`endif
    rst_n = 1'b1;
    #1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      chk_bus(tag, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid);
      if (vecs[i].e_valid) begin
        chk({tag, ".if_pc"}, if_pc, vecs[i].e_pc);
        chk({tag, ".if_instr"}, if_instr, mem(vecs[i].e_pc));
      end
`ifdef FETCH_ALIGN_CHECK_EN
      chk({tag, ".misalign"}, {31'h0, fetch_misalign}, 32'h0);
`endif
      drive(vecs[i].br, vecs[i].tgt, vecs[i].gnt, vecs[i].rv, vecs[i].rd, vecs[i].rdy);
    end

    // Misaligned redirect from S_REQ (pc=0)
    drive(1, 32'h102, 0, 0, 32'h0, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk_bus("mis.enter", 1'b0, 32'h102, 1'b0);
    chk("mis.enter.flag", {31'h0, fetch_misalign}, 32'h1);
    drive(0, 32'h0, 1, 1, 32'h0, 1);
    chk_bus("mis.hold", 1'b0, 32'h102, 1'b0);
    chk("mis.hold.flag", {31'h0, fetch_misalign}, 32'h1);
    drive(1, 32'h200, 0, 0, 32'h0, 0);
    chk_bus("mis.leave", 1'b1, 32'h200, 1'b0);
    chk("mis.leave.flag", {31'h0, fetch_misalign}, 32'h0);
    // misaligned redirect in S_WAIT waits for the killed response
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    drive(1, 32'h106, 0, 0, 32'h0, 0);
    chk_bus("mis.wait", 1'b0, 32'h106, 1'b0);
    chk("mis.wait.flag", {31'h0, fetch_misalign}, 32'h0);
    drive(0, 32'h0, 0, 1, 32'h1234_5678, 0);
    chk_bus("mis.wfault", 1'b0, 32'h106, 1'b0);
    chk("mis.wfault.flag", {31'h0, fetch_misalign}, 32'h1);
    drive(1, 32'h300, 0, 0, 32'h0, 0);
    chk_bus("mis.wleave", 1'b1, 32'h300, 1'b0);
    chk("mis.wleave.flag", {31'h0, fetch_misalign}, 32'h0);
`else
    chk_bus("mis.align", 1'b1, 32'h100, 1'b0);
`endif

    // Reset while a fetch is outstanding; the late rvalid arrives in S_REQ
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    chk_bus("rst.wait", 1'b0, imem_addr, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_bus("rst.mid", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 32'h0, 0, 1, 32'hBAD0_BAD0, 0);
    chk_bus("rst.late", 1'b1, 32'h0, 1'b0);
    drive(0, 32'h0, 1, 0, 32'h0, 0);
    drive(0, 32'h0, 0, 1, mem(32'h0), 0);
    chk_bus("rst.refetch", 1'b0, 32'h4, 1'b1);
    chk("rst.refetch.if_pc", if_pc, 32'h0);
    chk("rst.refetch.if_instr", if_instr, mem(32'h0));

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule
